// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default widths for the I/D memory-port arbiter.
package mem_bus_arbiter_pkg;

   localparam int ADDR_W_DEF  = 64;
   localparam int LINE_W_DEF  = 256;
   localparam int TIMEOUT_DEF = 64;

   typedef enum logic [2:0] {
      IDLE,
      IRD,
      DRD,
      DWR,
      RESP
   } arb_state_t;

   typedef enum logic {
      GNT_I,
      GNT_D
   } grant_t;

   // Round-robin pick: a lone requester wins; on a tie the side not granted last time wins.
   function automatic grant_t rr_pick(input logic req_i, input logic req_d, input grant_t last);
      if (req_i && (!req_d || last == GNT_D)) return GNT_I;
      return GNT_D;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Hart-side (I and D) and memory-side signals of the shared line port.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int LINE_W = 256
);
   logic [ADDR_W-1:0] b_addr_i;
   logic              b_rd_i;
   logic [LINE_W-1:0] b_data_i;
   logic              b_dv_i;
   logic              b_err_i;

   logic [ADDR_W-1:0] b_addr;
   logic              b_rd;
   logic              b_wr;
   logic [LINE_W-1:0] b_data_out;
   logic [LINE_W-1:0] b_data_in;
   logic              b_dv;
   logic              b_wack;
   logic              b_err;

   logic [ADDR_W-1:0] m_addr;
   logic              m_rd;
   logic              m_wr;
   logic [LINE_W-1:0] m_wdata;
   logic [LINE_W-1:0] m_rdata;
   logic              m_dv;

   // Arbiter view.
   modport slave (
      input  b_addr_i, b_rd_i, b_addr, b_rd, b_wr, b_data_out, m_rdata, m_dv,
      output b_data_i, b_dv_i, b_err_i, b_data_in, b_dv, b_wack, b_err,
             m_addr, m_rd, m_wr, m_wdata
   );

   // Hart and memory view.
   modport master (
      output b_addr_i, b_rd_i, b_addr, b_rd, b_wr, b_data_out, m_rdata, m_dv,
      input  b_data_i, b_dv_i, b_err_i, b_data_in, b_dv, b_wack, b_err,
             m_addr, m_rd, m_wr, m_wdata
   );
endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// Per-transaction down-counter: loaded on grant, expires after TIMEOUT cycles of run.
module bus_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic start_i,
   input  logic run_i,
   output logic expire_o
);
   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (start_i) begin
         cnt_q <= CW'(TIMEOUT - 1);
      end else if (run_i && cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign expire_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-fetch and D-side buses.
// state | meaning
// IDLE  | sample requests, grant one side
// IRD   | I-side read on memory, wait for m_dv or timeout
// DRD   | D-side read on memory, wait for m_dv or timeout
// DWR   | single-cycle memory write strobe
// RESP  | one-cycle dv/wack/err pulse back to the hart
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int LINE_W  = LINE_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   mem_bus_arbiter_if.slave bus
);
   arb_state_t        state_q;
   grant_t            last_q;
   grant_t            gnt_d;
   logic              req_i;
   logic              req_d;
   logic              wd_start;
   logic              wd_run;
   logic              wd_expire;

   logic [ADDR_W-1:0] m_addr_q;
   logic              m_rd_q;
   logic              m_wr_q;
   logic [LINE_W-1:0] m_wdata_q;
   logic [LINE_W-1:0] b_data_i_q;
   logic              b_dv_i_q;
   logic              b_err_i_q;
   logic [LINE_W-1:0] b_data_in_q;
   logic              b_dv_q;
   logic              b_wack_q;
   logic              b_err_q;

   assign req_i    = bus.b_rd_i;
   assign req_d    = bus.b_rd | bus.b_wr;
   assign gnt_d    = rr_pick(req_i, req_d, last_q);
   assign wd_start = (state_q == IDLE) && (req_i || req_d);
   assign wd_run   = (state_q == IRD) || (state_q == DRD);

   bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk      (clk),
      .rst      (rst),
      .start_i  (wd_start),
      .run_i    (wd_run),
      .expire_o (wd_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         last_q      <= GNT_D;
         m_addr_q    <= '0;
         m_rd_q      <= 1'b0;
         m_wr_q      <= 1'b0;
         m_wdata_q   <= '0;
         b_data_i_q  <= '0;
         b_dv_i_q    <= 1'b0;
         b_err_i_q   <= 1'b0;
         b_data_in_q <= '0;
         b_dv_q      <= 1'b0;
         b_wack_q    <= 1'b0;
         b_err_q     <= 1'b0;
      end else begin
         b_data_i_q  <= '0;
         b_dv_i_q    <= 1'b0;
         b_err_i_q   <= 1'b0;
         b_data_in_q <= '0;
         b_dv_q      <= 1'b0;
         b_wack_q    <= 1'b0;
         b_err_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_i || req_d) begin
                  last_q <= gnt_d;
                  if (gnt_d == GNT_I) begin
                     m_addr_q <= bus.b_addr_i;
                     m_rd_q   <= 1'b1;
                     state_q  <= IRD;
                  end else if (bus.b_wr) begin
                     m_addr_q  <= bus.b_addr;
                     m_wr_q    <= 1'b1;
                     m_wdata_q <= bus.b_data_out;
                     state_q   <= DWR;
                  end else begin
                     m_addr_q <= bus.b_addr;
                     m_rd_q   <= 1'b1;
                     state_q  <= DRD;
                  end
               end
            end
            IRD, DRD: begin
               // A requester that illegally dropped out still has its access completed, but gets no pulse.
               if (bus.m_dv) begin
                  m_rd_q  <= 1'b0;
                  state_q <= RESP;
                  if (state_q == IRD) begin
                     b_dv_i_q   <= bus.b_rd_i;
                     b_data_i_q <= bus.b_rd_i ? bus.m_rdata : '0;
                  end else begin
                     b_dv_q      <= bus.b_rd;
                     b_data_in_q <= bus.b_rd ? bus.m_rdata : '0;
                  end
               end else if (wd_expire) begin
                  m_rd_q  <= 1'b0;
                  state_q <= RESP;
                  if (state_q == IRD) b_err_i_q <= bus.b_rd_i;
                  else                b_err_q   <= bus.b_rd;
               end
            end
            DWR: begin
               m_wr_q    <= 1'b0;
               m_wdata_q <= '0;
               b_wack_q  <= bus.b_wr;
               state_q   <= RESP;
            end
            RESP: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always @(posedge clk) begin
      if (!rst && state_q == IDLE)
         assert (!(bus.b_rd && bus.b_wr))
            else $warning("b_rd and b_wr both high; write served first, read left pending");
      if (!rst && state_q == IRD)
         assert (bus.b_rd_i) else $error("I-side read request dropped before completion");
      if (!rst && state_q == DRD)
         assert (bus.b_rd) else $error("D-side read request dropped before completion");
      if (!rst && state_q == DWR)
         assert (bus.b_wr) else $error("D-side write request dropped before completion");
   end

   assign bus.m_addr    = m_addr_q;
   assign bus.m_rd      = m_rd_q;
   assign bus.m_wr      = m_wr_q;
   assign bus.m_wdata   = m_wdata_q;
   assign bus.b_data_i  = b_data_i_q;
   assign bus.b_dv_i    = b_dv_i_q;
   assign bus.b_err_i   = b_err_i_q;
   assign bus.b_data_in = b_data_in_q;
   assign bus.b_dv      = b_dv_q;
   assign bus.b_wack    = b_wack_q;
   assign bus.b_err     = b_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: requester and memory models plus a response scoreboard.
module tb_mem_bus_arbiter;
   localparam int AW = 64;
   localparam int LW = 256;
   localparam int TO = 8;

   localparam logic [4:0] K_IDV   = 5'b10000;
   localparam logic [4:0] K_IERR  = 5'b01000;
   localparam logic [4:0] K_DDV   = 5'b00100;
   localparam logic [4:0] K_DWACK = 5'b00010;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

   mem_bus_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [4:0]    kind;
      logic [LW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_i(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
      if (a == 64'h8000_0000) return {32{8'hA5}};
      return {a, ~a, a + 64'd1, a ^ 64'h5A5A_5A5A_5A5A_5A5A};
   endfunction

   // Requester models: each side keeps its request up while it has work left,
   // dropping it on the edge that ends its dv/wack/err cycle.
   int            i_left = 0, d_rd_left = 0, d_wr_left = 0;
   logic [AW-1:0] i_addr = '0, d_addr = '0;
   logic [LW-1:0] d_wdata = '0;
   bit            i_done = 0, d_rd_done = 0, d_wr_done = 0;

   initial begin
      bus.b_rd_i = 0; bus.b_addr_i = '0;
      bus.b_rd = 0; bus.b_wr = 0; bus.b_addr = '0; bus.b_data_out = '0;
      forever begin
         @(negedge clk);
         if (bus.b_rd_i && (bus.b_dv_i || bus.b_err_i)) i_done = 1;
         if (bus.b_rd && (bus.b_dv || bus.b_err)) d_rd_done = 1;
         if (bus.b_wr && bus.b_wack) d_wr_done = 1;
         @(posedge clk); #1;
         if (i_done) begin i_left--; i_done = 0; end
         if (d_rd_done) begin d_rd_left--; d_rd_done = 0; end
         if (d_wr_done) begin d_wr_left--; d_wr_done = 0; end
         bus.b_rd_i = (i_left > 0);
         bus.b_addr_i = i_addr;
         bus.b_rd = (d_rd_left > 0);
         bus.b_wr = (d_wr_left > 0);
         bus.b_addr = d_addr;
         bus.b_data_out = d_wdata;
      end
   end

   // Memory model: answers a read mem_delay cycles after m_rd rises unless silent.
   int mem_delay = 1;
   bit mem_silent = 0;
   bit inject = 0;
   int k = 0;

   initial begin
      bus.m_dv = 0; bus.m_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (bus.m_dv) begin
            bus.m_dv = 0; bus.m_rdata = '0; k = 0;
         end else if (inject) begin
            bus.m_dv = 1; bus.m_rdata = {8{32'hDEAD_BEEF}}; inject = 0;
         end else if (bus.m_rd && !mem_silent) begin
            if (k == mem_delay) begin
               bus.m_dv = 1; bus.m_rdata = line_of(bus.m_addr);
            end else k++;
         end else k = 0;
      end
   end

   // Scoreboard: every response pulse must match the next expected entry.
   logic [4:0]    obs_k;
   logic [LW-1:0] obs_d;
   exp_t          e;

   always @(negedge clk) begin
      if (!rst) begin
         check("b_data_i_zero_without_dv", bus.b_dv_i ? '0 : bus.b_data_i, '0);
         check("b_data_in_zero_without_dv", bus.b_dv ? '0 : bus.b_data_in, '0);
         obs_k = {bus.b_dv_i, bus.b_err_i, bus.b_dv, bus.b_wack, bus.b_err};
         obs_d = bus.b_dv_i ? bus.b_data_i : (bus.b_dv ? bus.b_data_in : '0);
         if (obs_k != 5'b0) begin
            check_i("resp_was_expected", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("resp_kind", LW'(obs_k), LW'(e.kind));
               check("resp_data", obs_d, e.data);
            end
         end
      end
   end

   int            t_req, t_mrd, t_mwr, t_mdv, t_resp;
   int            n_mrd, n_mwr, n_idv, n_ddv, n_ierr, n_wack, n_resp;
   logic [AW-1:0] wr_addr;
   logic [LW-1:0] wr_data;

   task automatic clear_stats();
      t_req = -1; t_mrd = -1; t_mwr = -1; t_mdv = -1; t_resp = -1;
      n_mrd = 0; n_mwr = 0; n_idv = 0; n_ddv = 0; n_ierr = 0; n_wack = 0; n_resp = 0;
      wr_addr = '0; wr_data = '0;
   endtask

   task automatic sample();
      if (t_req < 0 && (bus.b_rd_i || bus.b_rd || bus.b_wr)) t_req = cyc;
      if (bus.m_rd) begin n_mrd++; if (t_mrd < 0) t_mrd = cyc; end
      if (bus.m_wr) begin
         n_mwr++; if (t_mwr < 0) t_mwr = cyc;
         wr_addr = bus.m_addr; wr_data = bus.m_wdata;
      end
      if (bus.m_dv && t_mdv < 0) t_mdv = cyc;
      if (bus.b_dv_i) n_idv++;
      if (bus.b_err_i) n_ierr++;
      if (bus.b_dv) n_ddv++;
      if (bus.b_wack) n_wack++;
      if (bus.b_dv_i || bus.b_err_i || bus.b_dv || bus.b_wack || bus.b_err) begin
         n_resp++; if (t_resp < 0) t_resp = cyc;
      end
   endtask

   task automatic run(input string tag, input int budget);
      int  n;
      bit  done;
      n = 0; done = 0;
      clear_stats();
      while (n < budget && !done) begin
         @(negedge clk);
         n++;
         sample();
         done = (exp_q.size() == 0) && i_left == 0 && d_rd_left == 0 && d_wr_left == 0;
      end
      check_i({tag, "_completed_in_budget"}, done ? 1 : 0, 1);
   endtask

   task automatic window(input int n);
      clear_stats();
      repeat (n) begin
         @(negedge clk);
         sample();
      end
   endtask

   initial begin
      bit found;
      repeat (3) @(negedge clk);
      check("reset_ctrl_outputs", LW'({bus.m_rd, bus.m_wr, bus.b_dv_i, bus.b_err_i,
                                       bus.b_dv, bus.b_wack, bus.b_err}), '0);
      check("reset_m_addr", LW'(bus.m_addr), '0);
      rst = 0;
      window(3);
      check_i("idle_no_activity", n_mrd + n_mwr + n_resp, 0);

      // 1: lone I-read with 4-cycle memory latency
      mem_delay = 4;
      i_addr = 64'h8000_0000;
      exp_q.push_back('{K_IDV, {32{8'hA5}}});
      i_left = 1;
      run("t1", 40);
      check_i("t1_m_rd_latency", t_mrd - t_req, 1);
      check_i("t1_m_dv_delay", t_mdv - t_mrd, 4);
      check_i("t1_dv_latency", t_resp - t_mdv, 1);
      check_i("t1_m_rd_cycles", n_mrd, 5);
      check_i("t1_dv_pulses", n_idv, 1);

      // 2: D-write
      mem_delay = 1;
      d_addr = 64'h100;
      d_wdata = 256'h1234;
      exp_q.push_back('{K_DWACK, '0});
      d_wr_left = 1;
      run("t2", 40);
      check_i("t2_m_wr_cycles", n_mwr, 1);
      check("t2_m_addr", LW'(wr_addr), LW'(64'h100));
      check("t2_m_wdata", wr_data, 256'h1234);
      check_i("t2_m_rd_cycles", n_mrd, 0);
      check_i("t2_m_wr_latency", t_mwr - t_req, 1);
      check_i("t2_wack_latency", t_resp - t_mwr, 1);
      check_i("t2_wack_pulses", n_wack, 1);

      // 3: both sides reading for three rounds; I wins the first tie
      i_addr = 64'h8000_0000;
      d_addr = 64'h200;
      for (int r = 0; r < 3; r++) begin
         exp_q.push_back('{K_IDV, line_of(64'h8000_0000)});
         exp_q.push_back('{K_DDV, line_of(64'h200)});
      end
      i_left = 3;
      d_rd_left = 3;
      run("t3", 120);
      check_i("t3_i_dv_pulses", n_idv, 3);
      check_i("t3_d_dv_pulses", n_ddv, 3);

      // 4: I-read timeout, late m_dv ignored, then a D-read succeeds
      mem_silent = 1;
      i_addr = 64'h3000;
      exp_q.push_back('{K_IERR, '0});
      i_left = 1;
      run("t4", 40);
      check_i("t4_m_rd_cycles", n_mrd, TO);
      check_i("t4_err_pulses", n_ierr, 1);
      check_i("t4_err_latency", t_resp - t_mrd, TO);
      inject = 1;
      window(6);
      check_i("t4_late_dv_ignored", n_resp, 0);
      mem_silent = 0;
      d_addr = 64'h500;
      exp_q.push_back('{K_DDV, line_of(64'h500)});
      d_rd_left = 1;
      run("t4b", 40);
      check_i("t4_next_d_read", n_ddv, 1);

      // 5: reset while DRD is waiting on memory
      mem_silent = 1;
      d_addr = 64'h600;
      d_rd_left = 1;
      found = 0;
      for (int n = 0; n < 10 && !found; n++) begin
         @(negedge clk);
         found = bus.m_rd;
      end
      check_i("t5_reached_drd", found ? 1 : 0, 1);
      @(negedge clk);
      @(posedge clk); #2;
      rst = 1;
      #1;
      check("t5_async_ctrl_zero", LW'({bus.m_rd, bus.m_wr, bus.b_dv_i, bus.b_err_i,
                                       bus.b_dv, bus.b_wack, bus.b_err}), '0);
      check("t5_async_m_addr_zero", LW'(bus.m_addr), '0);
      d_rd_left = 0;
      d_rd_done = 0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 0;
      inject = 1;
      window(6);
      check_i("t5_no_resp_after_reset", n_resp, 0);
      check_i("t5_no_m_rd_after_reset", n_mrd, 0);
      mem_silent = 0;

      // 6: simultaneous b_rd and b_wr, write first then read
      d_addr = 64'h40;
      d_wdata = {4{64'hCAFE_F00D_0BAD_BEEF}};
      exp_q.push_back('{K_DWACK, '0});
      exp_q.push_back('{K_DDV, line_of(64'h40)});
      d_wr_left = 1;
      d_rd_left = 1;
      run("t6", 60);
      check_i("t6_m_wr_cycles", n_mwr, 1);
      check("t6_m_addr", LW'(wr_addr), LW'(64'h40));
      check("t6_m_wdata", wr_data, {4{64'hCAFE_F00D_0BAD_BEEF}});
      check_i("t6_write_first", t_resp - t_mwr, 1);
      check_i("t6_wack_pulses", n_wack, 1);
      check_i("t6_dv_pulses", n_ddv, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
